// File: rtl/vram_arbiter_pkg.sv
// Shared owner-tag and FSM encodings for the VRAM arbiter.
package vram_arbiter_pkg;

  localparam int TAG_WIDTH = 2;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_REN  = 2'd1;
  localparam logic [1:0] TAG_MPU  = 2'd2;

  // State codes match the tag codes so the owning state doubles as the read tag
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REN  = 2'd1;
  localparam logic [1:0] ST_MPU  = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } rd_tag_t;

  function automatic logic [TAG_WIDTH-1:0] state_to_tag(input logic [1:0] st);
    case (st)
      ST_REN:  state_to_tag = TAG_REN;
      ST_MPU:  state_to_tag = TAG_MPU;
      default: state_to_tag = TAG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and VRAM port bundle; slave = arbiter view, master = requesters/VRAM view.
interface vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          ren_req;
  logic          ren_wr;
  logic [1:0]    ren_be;
  logic [AW-1:0] ren_addr;
  logic          ren_grant;
  logic          ren_rdata_valid;
  logic [DW-1:0] ren_rdata;

  logic          mpu_req;
  logic          mpu_wr;
  logic [1:0]    mpu_be;
  logic [AW-1:0] mpu_addr;
  logic [DW-1:0] mpu_wdata;
  logic          mpu_grant;
  logic          mpu_rdata_valid;
  logic [DW-1:0] mpu_rdata;

  logic          vram_en;
  logic          vram_rd;
  logic          vram_wr;
  logic [1:0]    vram_be;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_data_out;
  logic [DW-1:0] vram_data_in;

  modport slave (
    input  ren_req, ren_wr, ren_be, ren_addr,
    output ren_grant, ren_rdata_valid, ren_rdata,
    input  mpu_req, mpu_wr, mpu_be, mpu_addr, mpu_wdata,
    output mpu_grant, mpu_rdata_valid, mpu_rdata,
    output vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out,
    input  vram_data_in
  );

  modport master (
    output ren_req, ren_wr, ren_be, ren_addr,
    input  ren_grant, ren_rdata_valid, ren_rdata,
    output mpu_req, mpu_wr, mpu_be, mpu_addr, mpu_wdata,
    input  mpu_grant, mpu_rdata_valid, mpu_rdata,
    input  vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out,
    output vram_data_in
  );
endinterface

// File: rtl/vram_read_tag_pipe.sv
// Shift register of {valid, owner tag} that lines a read up with vram_data_in.
module vram_read_tag_pipe
  import vram_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  // Advance one stage per cycle; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Renderer-priority VRAM arbiter with MPU starvation guard and tagged read return.
// Optional statistics counters are enabled with macro VRAM_ARB_STATS_EN.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int VRAM_ADDR_WIDTH = 16,
  parameter int VRAM_DATA_WIDTH = 16,
  parameter int READ_LATENCY    = 2,
  parameter int MPU_MAX_WAIT    = 8
) (
  input  logic        clk,
  input  logic        reset,
`ifdef VRAM_ARB_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_mpu_grants,
  output logic [15:0] stat_mpu_stall,
`endif
  vram_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_WAIT = 8'(MPU_MAX_WAIT);

  logic [7:0]                 r_wait_cnt;
  logic [1:0]                 r_state;
  logic                       w_ren_grant;
  logic                       w_mpu_grant;
  logic                       w_sel_wr;
  logic                       r_vram_en;
  logic                       r_vram_rd;
  logic                       r_vram_wr;
  logic [1:0]                 r_vram_be;
  logic [VRAM_ADDR_WIDTH-1:0] r_vram_addr;
  logic [VRAM_DATA_WIDTH-1:0] r_vram_data_out;
  logic                       r_ren_valid;
  logic                       r_mpu_valid;
  logic [VRAM_DATA_WIDTH-1:0] r_ren_rdata;
  logic [VRAM_DATA_WIDTH-1:0] r_mpu_rdata;
  rd_tag_t                    w_pipe_in;
  rd_tag_t                    w_pipe_out;

  // Grant decision from the live requests and the registered wait counter
  always_comb begin
    w_ren_grant = 1'b0;
    w_mpu_grant = 1'b0;
    if (!reset) begin
      w_ren_grant = 1'b0;
    end else if (bus.ren_req && bus.mpu_req) begin
      if (r_wait_cnt >= MAX_WAIT) w_mpu_grant = 1'b1;
      else                        w_ren_grant = 1'b1;
    end else if (bus.ren_req) begin
      w_ren_grant = 1'b1;
    end else if (bus.mpu_req) begin
      w_mpu_grant = 1'b1;
    end else begin
      w_ren_grant = 1'b0;
    end
  end

  assign w_sel_wr = w_mpu_grant ? bus.mpu_wr : bus.ren_wr;

  // Count consecutive MPU losses, saturating at the limit
  always_ff @(posedge clk) begin
    if (!reset)                              r_wait_cnt <= 8'd0;
    else if (w_mpu_grant || !bus.mpu_req)    r_wait_cnt <= 8'd0;
    else if (w_ren_grant && r_wait_cnt < MAX_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
    else                                     r_wait_cnt <= r_wait_cnt;
  end

  // Owner of the VRAM cycle being issued next
  always_ff @(posedge clk) begin
    if (!reset)           r_state <= ST_IDLE;
    else if (w_ren_grant) r_state <= ST_REN;
    else if (w_mpu_grant) r_state <= ST_MPU;
    else                  r_state <= ST_IDLE;
  end

  // Register the granted command onto the VRAM port for one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vram_en       <= 1'b0;
      r_vram_rd       <= 1'b0;
      r_vram_wr       <= 1'b0;
      r_vram_be       <= 2'b00;
      r_vram_addr     <= '0;
      r_vram_data_out <= '0;
    end else if (w_ren_grant || w_mpu_grant) begin
      r_vram_en       <= 1'b1;
      r_vram_rd       <= !w_sel_wr;
      r_vram_wr       <= w_sel_wr;
      r_vram_be       <= w_mpu_grant ? bus.mpu_be : bus.ren_be;
      r_vram_addr     <= w_mpu_grant ? bus.mpu_addr : bus.ren_addr;
      r_vram_data_out <= (w_mpu_grant && bus.mpu_wr) ? bus.mpu_wdata : '0;
    end else begin
      r_vram_en       <= 1'b0;
      r_vram_rd       <= 1'b0;
      r_vram_wr       <= 1'b0;
      r_vram_data_out <= '0;
    end
  end

  assign w_pipe_in = '{valid: r_vram_rd, tag: state_to_tag(r_state)};

  vram_read_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_pipe_in),
    .o_tag (w_pipe_out)
  );

  // Steer returning data to its owner; the other side keeps its last value
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ren_valid <= 1'b0;
      r_mpu_valid <= 1'b0;
      r_ren_rdata <= '0;
      r_mpu_rdata <= '0;
    end else begin
      r_ren_valid <= 1'b0;
      r_mpu_valid <= 1'b0;
      if (w_pipe_out.valid && w_pipe_out.tag == TAG_REN) begin
        r_ren_valid <= 1'b1;
        r_ren_rdata <= bus.vram_data_in;
      end else if (w_pipe_out.valid && w_pipe_out.tag == TAG_MPU) begin
        r_mpu_valid <= 1'b1;
        r_mpu_rdata <= bus.vram_data_in;
      end else begin
        r_ren_rdata <= r_ren_rdata;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stat_grants;
  logic [15:0] r_stat_stall;

  // MPU grant and stall counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (!reset || stat_clr) begin
      r_stat_grants <= 16'd0;
      r_stat_stall  <= 16'd0;
    end else begin
      if (w_mpu_grant)                 r_stat_grants <= r_stat_grants + 16'd1;
      else                             r_stat_grants <= r_stat_grants;
      if (bus.mpu_req && !w_mpu_grant) r_stat_stall  <= r_stat_stall + 16'd1;
      else                             r_stat_stall  <= r_stat_stall;
    end
  end

  assign stat_mpu_grants = r_stat_grants;
  assign stat_mpu_stall  = r_stat_stall;
`endif

  assign bus.ren_grant       = w_ren_grant;
  assign bus.mpu_grant       = w_mpu_grant;
  assign bus.vram_en         = r_vram_en;
  assign bus.vram_rd         = r_vram_rd;
  assign bus.vram_wr         = r_vram_wr;
  assign bus.vram_be         = r_vram_be;
  assign bus.vram_addr       = r_vram_addr;
  assign bus.vram_data_out   = r_vram_data_out;
  assign bus.ren_rdata_valid = r_ren_valid;
  assign bus.ren_rdata       = r_ren_rdata;
  assign bus.mpu_rdata_valid = r_mpu_valid;
  assign bus.mpu_rdata       = r_mpu_rdata;

endmodule
